// File: rtl/set_job_dispatcher_if.sv
// Job, SET-core and result handshake signals of set_job_dispatcher, bundled as one port.
// slave = the dispatcher itself, master = the surrounding job source / SET core / consumer.
interface set_job_dispatcher_if #(
    parameter int DEPTH = 4
);
    logic                   job_valid;
    logic                   job_ready;
    logic [23:0]            job_central;
    logic [11:0]            job_radius;
    logic [1:0]             job_mode;
    logic                   set_en;
    logic [23:0]            set_central;
    logic [11:0]            set_radius;
    logic [1:0]             set_mode;
    logic                   set_busy;
    logic                   set_valid;
    logic [7:0]             set_candidate;
    logic                   res_valid;
    logic                   res_ready;
    logic [7:0]             res_candidate;
    logic [5:0]             res_tag;
    logic                   res_err;
    logic [$clog2(DEPTH):0] fifo_count;

    modport slave (
        input  job_valid, job_central, job_radius, job_mode,
        input  set_busy, set_valid, set_candidate, res_ready,
        output job_ready, set_en, set_central, set_radius, set_mode,
        output res_valid, res_candidate, res_tag, res_err, fifo_count
    );

    modport master (
        output job_valid, job_central, job_radius, job_mode,
        output set_busy, set_valid, set_candidate, res_ready,
        input  job_ready, set_en, set_central, set_radius, set_mode,
        input  res_valid, res_candidate, res_tag, res_err, fifo_count
    );
endinterface

// File: rtl/set_job_dispatcher.sv
// Buffers SET jobs in a FIFO, issues them one at a time and returns tagged results.
// Optional watchdog on the SET response enabled by defining SET_DISP_TIMEOUT_EN.
module set_job_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input logic            clk,
    input logic            rst,
    set_job_dispatcher_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int JOB_W = 38;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [JOB_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic             set_en_q, set_en_d;
    logic [JOB_W-1:0] set_job_q, set_job_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_cand_q, res_cand_d;
    logic [5:0]       res_tag_q, res_tag_d;
    logic             res_err_q, res_err_d;
    logic [5:0]       tag_q, tag_d;
    logic             push, pop, timeout_hit;

    assign bus.job_ready     = (count_q < FULL_CNT);
    assign bus.fifo_count    = count_q;
    assign bus.set_en        = set_en_q;
    assign bus.set_central   = set_job_q[37:14];
    assign bus.set_radius    = set_job_q[13:2];
    assign bus.set_mode      = set_job_q[1:0];
    assign bus.res_valid     = res_valid_q;
    assign bus.res_candidate = res_cand_q;
    assign bus.res_tag       = res_tag_q;
    assign bus.res_err       = res_err_q;

    assign push = bus.job_valid && bus.job_ready;
    // A new job only leaves the FIFO once the single result slot is free.
    assign pop  = (state_q == IDLE) && (count_q != '0) && !bus.set_busy && !res_valid_q;

`ifdef SET_DISP_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [TCNT_W-1:0] TLIM = TCNT_W'(TIMEOUT - 2);
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == ISSUE) tcnt_d = '0;
        else if (state_q == WAIT) tcnt_d = tcnt_q + 1'b1;
    end

    // Counter starts the cycle after en, so firing at TIMEOUT-2 lands res_valid TIMEOUT cycles after en.
    assign timeout_hit = (state_q == WAIT) && (tcnt_q == TLIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tcnt_q <= '0;
        else      tcnt_q <= tcnt_d;
    end
`else
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        set_en_d    = 1'b0;
        set_job_d   = set_job_q;
        res_valid_d = res_valid_q;
        res_cand_d  = res_cand_q;
        res_tag_d   = res_tag_q;
        res_err_d   = res_err_q;
        tag_d       = tag_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = ISSUE;
                    set_en_d  = 1'b1;
                    set_job_d = mem_q[rd_ptr_q];
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A real SET result beats a watchdog expiry in the same cycle.
                if (bus.set_valid || timeout_hit) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b1;
                    res_cand_d  = bus.set_valid ? bus.set_candidate : 8'd0;
                    res_err_d   = !bus.set_valid;
                    res_tag_d   = tag_q;
                    tag_d       = tag_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.job_central, bus.job_radius, bus.job_mode};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            set_en_q    <= 1'b0;
            set_job_q   <= '0;
            res_valid_q <= 1'b0;
            res_cand_q  <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
            tag_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            set_en_q    <= set_en_d;
            set_job_q   <= set_job_d;
            res_valid_q <= res_valid_d;
            res_cand_q  <= res_cand_d;
            res_tag_q   <= res_tag_d;
            res_err_q   <= res_err_d;
            tag_q       <= tag_d;
        end
    end
endmodule

// File: tb/tb_set_job_dispatcher.sv
// Self-checking bench for set_job_dispatcher: behavioural job/result model plus directed scenarios.
`timescale 1ns/1ps
module tb_set_job_dispatcher;
    localparam int DEPTH = 4;
`ifdef SET_DISP_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 1024;
`endif

    typedef struct packed {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    set_job_dispatcher_if #(.DEPTH(DEPTH)) bus ();
    set_job_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int  checks = 0;
    int  errors = 0;
    bit  rand_mode = 0, set_silent = 0, spurious_en = 0;
    logic rr_fix = 1'b0, busy_fix = 1'b0, rr_rand = 1'b1, busy_rand = 1'b0;
    assign bus.res_ready = rand_mode ? rr_rand : rr_fix;
    assign bus.set_busy  = rand_mode ? busy_rand : busy_fix;

    // reference state
    job_t       mq[$];
    logic [7:0] sb[$];
    job_t       m_cur;
    bit         m_en, m_fly, m_rv, m_re;
    logic [7:0] m_rc;
    logic [5:0] m_rt, m_tag;
    int         m_since, res_idx, en_count;

    function automatic logic [7:0] cand_of(job_t j);
        if (j.c == 24'h446688 && j.r == 12'h333 && j.m == 2'd0) return 8'd25;
        return j.c[7:0] + j.c[15:8] + j.r[7:0] + {6'd0, j.m};
    endfunction

    function automatic job_t rand_job();
        job_t j;
        j.c = 24'($urandom);
        j.r = 12'($urandom);
        j.m = 2'($urandom);
        return j;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete(); sb.delete();
        m_cur = '0; m_en = 0; m_fly = 0; m_rv = 0; m_re = 0;
        m_rc = '0; m_rt = '0; m_tag = '0; m_since = 0; res_idx = 0;
    endtask

    task automatic model_finish(logic [7:0] cand, bit err);
        m_fly = 0; m_rv = 1; m_rc = cand; m_re = err; m_rt = m_tag; m_tag = m_tag + 6'd1;
    endtask

    task automatic model_step();
        job_t j;
        bit push, issue;
        push  = bus.job_valid && (mq.size() < DEPTH);
        issue = !m_fly && (mq.size() > 0) && !bus.set_busy && !m_rv;
        if (m_rv && bus.res_ready) m_rv = 0;
        if (m_en) begin
            m_en = 0; m_since = 1;
        end else if (m_fly) begin
            if (bus.set_valid) model_finish(bus.set_candidate, 0);
`ifdef SET_DISP_TIMEOUT_EN
            else if (m_since == TIMEOUT - 1) model_finish(8'd0, 1);
`endif
            else m_since++;
        end else if (issue) begin
            m_cur = mq.pop_front(); m_en = 1; m_fly = 1;
        end
        if (push) begin
            j = {bus.job_central, bus.job_radius, bus.job_mode};
            mq.push_back(j);
            sb.push_back(cand_of(j));
        end
    endtask

    // compare process: outputs vs. model every cycle, then advance the model
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_set_en", 64'(bus.set_en), 64'd0);
                check("rst_res_valid", 64'(bus.res_valid), 64'd0);
                check("rst_count", 64'(bus.fifo_count), 64'd0);
                check("rst_set_job", 64'({bus.set_central, bus.set_radius, bus.set_mode}), 64'd0);
                check("rst_res", 64'({bus.res_candidate, bus.res_tag, bus.res_err}), 64'd0);
                model_reset();
                continue;
            end
            check("job_ready", 64'(bus.job_ready), 64'(mq.size() < DEPTH));
            check("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
            check("set_en", 64'(bus.set_en), 64'(m_en));
            check("set_job", 64'({bus.set_central, bus.set_radius, bus.set_mode}), 64'(m_cur));
            check("res_valid", 64'(bus.res_valid), 64'(m_rv));
            if (m_rv) begin
                check("res_candidate", 64'(bus.res_candidate), 64'(m_rc));
                check("res_tag", 64'(bus.res_tag), 64'(m_rt));
                check("res_err", 64'(bus.res_err), 64'(m_re));
            end
            if (bus.res_valid && bus.res_ready && !set_silent) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_order got=unexpected_result exp=none t=%0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("sb_cand", 64'(bus.res_candidate), 64'(e));
                    check("sb_tag", 64'(bus.res_tag), 64'(res_idx % 64));
                end
                if (res_idx == 64) check("wrap_tag", 64'(bus.res_tag), 64'd0);
                res_idx++;
            end
            if (bus.set_en) en_count++;
            model_step();
        end
    end

    // SET core stand-in: answers each en after 1..5 cycles
    initial begin
        job_t jj;
        int lat;
        bus.set_valid = 1'b0; bus.set_candidate = 8'd0;
        forever begin
            @(posedge clk); #1;
            bus.set_valid = 1'b0;
            if (rst && bus.set_en && !set_silent) begin
                jj  = {bus.set_central, bus.set_radius, bus.set_mode};
                lat = $urandom_range(1, 5);
                repeat (lat) begin @(posedge clk); #1; end
                bus.set_valid = 1'b1; bus.set_candidate = cand_of(jj);
            end else if (spurious_en && !bus.set_en && $urandom_range(0, 15) == 0) begin
                bus.set_valid = 1'b1; bus.set_candidate = 8'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            rr_rand   = ($urandom_range(0, 3) != 0);
            busy_rand = ($urandom_range(0, 7) == 0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic push_job(job_t j);
        bit acc;
        int g = 0;
        bus.job_valid = 1'b1;
        {bus.job_central, bus.job_radius, bus.job_mode} = j;
        do begin
            acc = bus.job_ready;
            tick();
            g++;
        end while (!acc && g < 500);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_timeout got=not_accepted exp=accepted t=%0t", $time);
        end
    endtask

    task automatic wait_results(string name, int n, int limit);
        int g = 0;
        while (res_idx < n && g < limit) begin tick(); g++; end
        check(name, 64'(res_idx), 64'(n));
    endtask

    task automatic wait_res_valid(string name, int limit);
        int g = 0;
        while (!bus.res_valid && g < limit) begin tick(); g++; end
        check(name, 64'(bus.res_valid), 64'd1);
    endtask

    initial begin
        job_t j;
        logic [7:0] held;
        int e0, k;
        bit saw_full;
        bus.job_valid = 1'b0; bus.job_central = '0; bus.job_radius = '0; bus.job_mode = '0;
        #1;

        // single job with known answer
        do_reset();
        rr_fix = 1'b0;
        bus.job_valid = 1'b1; bus.job_central = 24'h446688; bus.job_radius = 12'h333; bus.job_mode = 2'd0;
        tick();
        bus.job_valid = 1'b0;
        check("t1_en_early", 64'(bus.set_en), 64'd0);
        tick();
        check("t1_en", 64'(bus.set_en), 64'd1);
        tick();
        check("t1_en_once", 64'(bus.set_en), 64'd0);
        wait_res_valid("t1_res_valid", 50);
        check("t1_cand", 64'(bus.res_candidate), 64'd25);
        check("t1_tag", 64'(bus.res_tag), 64'd0);
        check("t1_err", 64'(bus.res_err), 64'd0);
        rr_fix = 1'b1; tick(); tick();
        check("t1_res_cleared", 64'(bus.res_valid), 64'd0);

        // five back-to-back jobs into a depth-4 FIFO
        do_reset();
        rr_fix = 1'b1;
        saw_full = 0;
        for (int i = 0; i < 5; i++) begin
            push_job(rand_job());
            if (bus.fifo_count == 3'(DEPTH) && !bus.job_ready) saw_full = 1;
        end
        bus.job_valid = 1'b0;
        check("t2_full_seen", 64'(saw_full), 64'd1);
        wait_results("t2_results", 5, 400);

        // result slot held -> no further issue
        do_reset();
        rr_fix = 1'b0;
        push_job(rand_job()); push_job(rand_job());
        bus.job_valid = 1'b0;
        wait_res_valid("t3_res_valid", 50);
        held = bus.res_candidate;
        e0 = en_count;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("t3_cand_stable", 64'(bus.res_candidate), 64'(held));
        end
        check("t3_no_en", 64'(en_count), 64'(e0));
        rr_fix = 1'b1;
        wait_results("t3_results", 2, 200);

        // busy blocks issue; en follows busy falling
        do_reset();
        busy_fix = 1'b1;
        for (int i = 0; i < 3; i++) push_job(rand_job());
        bus.job_valid = 1'b0;
        e0 = en_count;
        repeat (20) tick();
        check("t4_no_en_busy", 64'(en_count), 64'(e0));
        busy_fix = 1'b0;
        tick();
        check("t4_en_after_busy", 64'(bus.set_en), 64'd1);
        wait_results("t4_results", 3, 300);

        // randomized stream, long enough to wrap the tag
        do_reset();
        rand_mode = 1; spurious_en = 1;
        for (int i = 0; i < 70; i++) begin
            push_job(rand_job());
            bus.job_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_results("t5_results", 70, 3000);
        rand_mode = 0; spurious_en = 0; rr_fix = 1'b1; busy_fix = 1'b0;

        // reset while waiting on SET abandons the job
        do_reset();
        set_silent = 1; rr_fix = 1'b1;
        push_job(rand_job());
        bus.job_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b0;
        #1;
        check("t6_rst_en", 64'(bus.set_en), 64'd0);
        check("t6_rst_set", 64'({bus.set_central, bus.set_radius, bus.set_mode}), 64'd0);
        check("t6_rst_count", 64'(bus.fifo_count), 64'd0);
        tick(); tick();
        rst = 1'b1;
        e0 = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.res_valid) e0++;
        end
        check("t6_no_result", 64'(e0), 64'd0);

`ifdef SET_DISP_TIMEOUT_EN
        // watchdog expiry
        do_reset();
        rr_fix = 1'b0;
        push_job(rand_job());
        bus.job_valid = 1'b0;
        k = 0;
        while (!bus.set_en && k < 50) begin tick(); k++; end
        check("t7_en_seen", 64'(bus.set_en), 64'd1);
        k = 0;
        while (!bus.res_valid && k < 100) begin tick(); k++; end
        check("t7_timeout_lat", 64'(k), 64'd16);
        check("t7_err", 64'(bus.res_err), 64'd1);
        check("t7_cand", 64'(bus.res_candidate), 64'd0);
        check("t7_tag", 64'(bus.res_tag), 64'd0);
`endif
        set_silent = 0;
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
